lsu_initiator: RTL and testbench

- Load/store unit on the processor side of the Data_Cache interface; initiator of the memory transaction that the cache answers.
- Takes the memory-read and memory-write controls, the ALU address and store data from the datapath, and issues one cache request at a time using a req/gnt plus rvalid handshake.
- Holds the datapath with a stall while the request is outstanding, then returns load data and a one-cycle done pulse.
- Replaces the direct combinational hookup between the ALU, Operand_Prep and Data_Cache.

---
 rtl/lsu_pkg.sv | 7 +
 rtl/lsu_timeout_counter.sv | 22 ++
 rtl/lsu_initiator.sv | 96 +++++++++
 tb/tb_lsu_initiator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, default widths and alignment mask for the load/store initiator
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;
endpackage

// File: rtl/lsu_timeout_counter.sv
// lsu_timeout_counter: counts WAIT cycles and flags the last cycle before the response deadline
module lsu_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear wins over enable so a fresh WAIT always starts from zero
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // fires on the cycle whose closing edge brings the count to TIMEOUT_CYCLES
  assign expire_o = en_i && cnt_q == LAST;
endmodule

// File: rtl/lsu_initiator.sv
// lsu_initiator: single-outstanding req/gnt/rvalid initiator towards the data cache (LSU_MISALIGN_TRAP_EN traps misaligned requests)
module lsu_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state_q, state_d;
  logic stall_q, stall_d, done_q, done_d, err_q, err_d, req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic illegal, misalign, accept, complete, timeout, expire;
  lsu_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (state_q != WAIT),
    .en_i    (state_q == WAIT),
    .expire_o(expire)
  );
  // next state and next registered outputs; both-high requests are rejected without leaving IDLE
  always_comb begin
    illegal = state_q == IDLE && cpu_read && cpu_write;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = state_q == IDLE && (cpu_read ^ cpu_write) && |(cpu_addr[1:0] & ADDR_ALIGN_MASK);
`else
    misalign = 1'b0;
`endif
    accept = state_q == IDLE && (cpu_read ^ cpu_write) && !misalign;
    complete = mem_rvalid && ((state_q == REQ && mem_gnt) || state_q == WAIT);
    timeout = state_q == WAIT && !mem_rvalid && expire;
    state_d = accept ? REQ
            : state_q == REQ && mem_gnt ? (mem_rvalid ? DONE : WAIT)
            : complete || timeout ? DONE
            : state_q == DONE ? IDLE
            : state_q;
    req_d = state_d == REQ;
    stall_d = state_d == REQ || state_d == WAIT;
    done_d = state_d == DONE || illegal || misalign;
    err_d = timeout || illegal || misalign;
    we_d = accept ? cpu_write : we_q;
    addr_d = accept ? cpu_addr & ~{{(ADDR_W-2){1'b0}}, ADDR_ALIGN_MASK} : addr_q;
    wdata_d = accept ? cpu_wdata : wdata_q;
    rdata_d = complete && !we_q ? mem_rdata : rdata_q;
  end
  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign cpu_stall = stall_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_initiator.sv
// tb_lsu_initiator: directed bench with a completion scoreboard for lsu_initiator (honours LSU_MISALIGN_TRAP_EN)
module tb_lsu_initiator;
  logic clock = 1'b0, reset = 1'b1;
  logic cpu_read = 1'b0, cpu_write = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic cpu_stall, cpu_done, cpu_err, mem_req, mem_we;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_err = 0;
  lsu_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clock);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, {31'd0, mem_req}, 0);
    chk({tag, "_stall"}, {31'd0, cpu_stall}, 0);
    chk({tag, "_done"}, {31'd0, cpu_done}, 0);
    chk({tag, "_err"}, {31'd0, cpu_err}, 0);
  endtask
  always @(negedge clock) begin
    if (cpu_done) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_done: observed unexpected cpu_done expected none");
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rdata", cpu_rdata, e.rdata);
        chk("sb_err", {31'd0, cpu_err}, {31'd0, e.err});
      end
    end
  end
  initial begin
    int k;
    repeat (2) step();
    chk_idle("rst");
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    reset = 1'b0;
    step();
    // load with zero-wait cache
    cpu_read = 1'b1; cpu_addr = 32'h0000_0010;
    sb.push_back('{rdata: 32'hCAFE_0001, err: 1'b0});
    step();
    cpu_read = 1'b0; cpu_addr = 32'hFFFF_FFFF;
    chk("ld_req", {31'd0, mem_req}, 1);
    chk("ld_we", {31'd0, mem_we}, 0);
    chk("ld_addr", mem_addr, 32'h10);
    chk("ld_stall1", {31'd0, cpu_stall}, 1);
    chk("ld_done_early", {31'd0, cpu_done}, 0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("ld_req_wait", {31'd0, mem_req}, 0);
    chk("ld_stall2", {31'd0, cpu_stall}, 1);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h5555_5555;
    chk("ld_done", {31'd0, cpu_done}, 1);
    chk("ld_stall_fall", {31'd0, cpu_stall}, 0);
    step();
    chk_idle("ld_after");
    // store with grant withheld for four cycles
    cpu_write = 1'b1; cpu_addr = 32'h0000_0024; cpu_wdata = 32'h1234_5678;
    sb.push_back('{rdata: 32'hCAFE_0001, err: 1'b0});
    for (int i = 0; i < 5; i++) begin
      step();
      cpu_write = 1'b0; cpu_addr = 32'h0000_0100 + i; cpu_wdata = 32'hA5A5_0000 + i;
      chk("st_req", {31'd0, mem_req}, 1);
      chk("st_we", {31'd0, mem_we}, 1);
      chk("st_addr", mem_addr, 32'h24);
      chk("st_wdata", mem_wdata, 32'h1234_5678);
      mem_gnt = i == 4;
    end
    step();
    mem_gnt = 1'b0;
    chk("st_req_wait", {31'd0, mem_req}, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    chk("st_done", {31'd0, cpu_done}, 1);
    step();
    // timeout with TIMEOUT_CYCLES = 8
    cpu_read = 1'b1; cpu_addr = 32'h0000_0030;
    sb.push_back('{rdata: 32'hCAFE_0001, err: 1'b1});
    step();
    cpu_read = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rdata = 32'h9999_9999;
    k = 1;
    while (!cpu_done && k < 20) begin
      step();
      k++;
    end
    chk("tmo_latency", k, 9);
    chk("tmo_err", {31'd0, cpu_err}, 1);
    step();
    // next request, grant and rvalid in the same cycle
    cpu_read = 1'b1; cpu_addr = 32'h0000_0040;
    sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
    step();
    cpu_read = 1'b0;
    chk("gr_req", {31'd0, mem_req}, 1);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("gr_done", {31'd0, cpu_done}, 1);
    step();
    // illegal both-high request
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h0000_0060;
    sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b1});
    step();
    cpu_read = 1'b0; cpu_write = 1'b0;
    chk("ill_req", {31'd0, mem_req}, 0);
    chk("ill_stall", {31'd0, cpu_stall}, 0);
    chk("ill_done", {31'd0, cpu_done}, 1);
    step();
    chk_idle("ill_after");
    // reset two cycles after grant, late rvalid ignored
    cpu_read = 1'b1; cpu_addr = 32'h0000_0050;
    step();
    cpu_read = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    chk_idle("rw_rst");
    chk("rw_rdata", cpu_rdata, 0);
    chk("rw_addr", mem_addr, 0);
    step();
    mem_rvalid = 1'b0;
    chk_idle("rw_late");
    chk("rw_rdata_late", cpu_rdata, 0);
    // misaligned address 0x13
    cpu_read = 1'b1; cpu_addr = 32'h0000_0013;
`ifdef LSU_MISALIGN_TRAP_EN
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    step();
    cpu_read = 1'b0;
    chk("mis_req", {31'd0, mem_req}, 0);
    chk("mis_stall", {31'd0, cpu_stall}, 0);
    chk("mis_done", {31'd0, cpu_done}, 1);
`else
    sb.push_back('{rdata: 32'h0000_0055, err: 1'b0});
    step();
    cpu_read = 1'b0;
    chk("mis_req", {31'd0, mem_req}, 1);
    chk("mis_addr", mem_addr, 32'h10);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
    step();
    mem_rvalid = 1'b0;
    chk("mis_done", {31'd0, cpu_done}, 1);
`endif
    step();
    step();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
